// File: rtl/vc_flit_buffer.sv
// ---------------------------------------------------------------------------
// vc_flit_buffer : per-VC flit FIFOs with a round-robin shared drain port
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module vc_flit_buffer #(
  parameter int FLIT_WIDTH = 128,
  parameter int NUM_VC     = 2,
  parameter int DEPTH      = 8,
  parameter int VCW        = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  in_valid,
  input  logic [VCW-1:0]        in_vc,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [VCW-1:0]        out_vc,
  output logic [FLIT_WIDTH-1:0] out_flit,
  input  logic                  out_ready,
  output logic [2*NUM_VC-1:0]   vc_state,
  output logic                  overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_EMPTY       = 2'b00;
  localparam logic [1:0] ST_VACANT      = 2'b01;
  localparam logic [1:0] ST_ALMOST_FULL = 2'b10;
  localparam logic [1:0] ST_FULL        = 2'b11;

  logic [FLIT_WIDTH-1:0] mem [NUM_VC][DEPTH];
  logic [PW-1:0]         head  [NUM_VC];
  logic [PW-1:0]         tail  [NUM_VC];
  logic [CW-1:0]         count [NUM_VC];
  logic [VCW-1:0]        last_grant;
  logic [VCW-1:0]        held_vc;
  logic                  locked;

  logic                  in_legal;
  logic [VCW-1:0]        in_idx;
  logic [VCW-1:0]        grant;
  logic [NUM_VC-1:0]     nonempty;
  logic [NUM_VC-1:0]     push_vc;
  logic [NUM_VC-1:0]     pop_vc;
  logic                  push;
  logic                  pop;
  logic                  found;
  int                    idx;

  assign in_legal = {1'b0, in_vc} < (VCW+1)'(NUM_VC);
  assign in_idx   = in_legal ? in_vc : '0;
  assign in_ready = in_legal && (count[in_idx] != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign out_valid = |nonempty;
  assign pop      = out_valid && out_ready;

  generate
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      assign nonempty[v] = count[v] != '0;
      assign push_vc[v]  = push && (in_idx == VCW'(v));
      assign pop_vc[v]   = pop && (grant == VCW'(v));
      assign vc_state[2*v +: 2] =
          (count[v] == '0)             ? ST_EMPTY :
          (count[v] == CW'(DEPTH))     ? ST_FULL :
          (count[v] == CW'(DEPTH - 1)) ? ST_ALMOST_FULL : ST_VACANT;
    end
  endgenerate

  // A stalled grant is pinned by the lock so a late push elsewhere cannot steal it.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    if (locked) begin
      grant = held_vc;
    end else begin
      for (int i = 1; i <= NUM_VC; i++) begin
        idx = (int'(last_grant) + i) % NUM_VC;
        if (!found && nonempty[idx]) begin
          grant = VCW'(idx);
          found = 1'b1;
        end
      end
    end
  end

  assign out_vc   = out_valid ? grant : '0;
  assign out_flit = out_valid ? mem[grant][head[grant]] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[in_idx][tail[in_idx]] <= in_flit;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        head[v]  <= '0;
        tail[v]  <= '0;
        count[v] <= '0;
      end
      last_grant <= VCW'(NUM_VC - 1);
      held_vc    <= '0;
      locked     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      overflow <= in_valid && !in_ready;
      for (int v = 0; v < NUM_VC; v++) begin
        if (push_vc[v]) tail[v] <= tail[v] + 1'b1;
        if (pop_vc[v])  head[v] <= head[v] + 1'b1;
        count[v] <= count[v] + CW'(push_vc[v]) - CW'(pop_vc[v]);
      end
      if (pop) begin
        last_grant <= grant;
        locked     <= 1'b0;
      end else if (out_valid) begin
        locked  <= 1'b1;
        held_vc <= grant;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vc_flit_buffer.sv
// ---------------------------------------------------------------------------
// tb_vc_flit_buffer : directed and randomized checks of vc_flit_buffer
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vc_flit_buffer;

  localparam int FW  = 128;
  localparam int NV  = 2;
  localparam int D   = 8;
  localparam int VCW = 1;

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic           in_valid = 1'b0;
  logic [VCW-1:0] in_vc = '0;
  logic [FW-1:0]  in_flit = '0;
  logic           in_ready;
  logic           out_valid;
  logic [VCW-1:0] out_vc;
  logic [FW-1:0]  out_flit;
  logic           out_ready = 1'b0;
  logic [2*NV-1:0] vc_state;
  logic           overflow;

  int total = 0;
  int bad = 0;

  // Reference model: one queue per channel plus arbitration bookkeeping.
  logic [FW-1:0] q [NV][$];
  int last_g = NV - 1;
  bit locked = 1'b0;
  int held = 0;
  bit exp_ovf = 1'b0;

  vc_flit_buffer #(.FLIT_WIDTH(FW), .NUM_VC(NV), .DEPTH(D), .VCW(VCW)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
    .in_ready(in_ready), .out_valid(out_valid), .out_vc(out_vc), .out_flit(out_flit),
    .out_ready(out_ready), .vc_state(vc_state), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic bit m_valid();
    for (int i = 0; i < NV; i++) if (q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_grant();
    if (locked) return held;
    for (int i = 1; i <= NV; i++) begin
      int k = (last_g + i) % NV;
      if (q[k].size() > 0) return k;
    end
    return 0;
  endfunction

  function automatic logic [VCW-1:0] m_vc();
    return m_valid() ? VCW'(m_grant()) : '0;
  endfunction

  function automatic logic [FW-1:0] m_flit();
    if (!m_valid()) return '0;
    return q[m_grant()][0];
  endfunction

  function automatic logic [2*NV-1:0] m_states();
    logic [2*NV-1:0] s;
    s = '0;
    for (int i = 0; i < NV; i++) begin
      int sz = q[i].size();
      s[2*i +: 2] = (sz == 0) ? 2'b00 : (sz == D) ? 2'b11 : (sz == D - 1) ? 2'b10 : 2'b01;
    end
    return s;
  endfunction

  function automatic bit m_ready();
    return (int'(in_vc) < NV) && (q[in_vc].size() < D);
  endfunction

  function automatic logic [FW-1:0] rnd_flit();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_in(input bit v, input int vc, input logic [FW-1:0] f, input bit r);
    in_valid  = v;
    in_vc     = vc[VCW-1:0];
    in_flit   = f;
    out_ready = r;
    #1;
  endtask

  task automatic tick();
    int g;
    bit v, pu, po;
    g  = m_grant();
    v  = m_valid();
    pu = in_valid && m_ready();
    po = v && out_ready;
    @(posedge clk);
    if (po) begin
      void'(q[g].pop_front());
      last_g = g;
      locked = 1'b0;
    end else if (v) begin
      locked = 1'b1;
      held   = g;
    end
    if (pu) q[in_vc].push_back(in_flit);
    exp_ovf = in_valid && !pu;
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) q[i].delete();
    last_g  = NV - 1;
    locked  = 1'b0;
    exp_ovf = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid actual=%b required=0", out_valid); end
    total++; if (out_vc !== '0) begin bad++; $display("FAIL reset_vc actual=%0d required=0", out_vc); end
    total++; if (out_flit !== '0) begin bad++; $display("FAIL reset_flit actual=%h required=0", out_flit); end
    total++; if (vc_state !== '0) begin bad++; $display("FAIL reset_state actual=%b required=0", vc_state); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow actual=%b required=0", overflow); end
    for (int v = 0; v < NV; v++) begin
      set_in(0, v, '0, 0);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready vc=%0d actual=%b required=1", v, in_ready); end
    end
  endtask

  task automatic test_basic();
    logic [FW-1:0] f;
    for (int i = 0; i < 3; i++) begin
      f = FW'(8'hA1 + i);
      set_in(1, 0, f, 0);
      tick();
    end
    set_in(0, 0, '0, 0);
    total++; if (vc_state[1:0] !== 2'b01) begin bad++; $display("FAIL basic_state actual=%b required=01", vc_state[1:0]); end
    total++; if (out_flit !== FW'(8'hA1)) begin bad++; $display("FAIL basic_head actual=%h required=a1", out_flit); end
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, '0, 1);
      f = FW'(8'hA1 + i);
      total++; if (out_flit !== f) begin bad++; $display("FAIL basic_pop%0d actual=%h required=%h", i, out_flit, f); end
      tick();
    end
    total++; if (vc_state[1:0] !== 2'b00) begin bad++; $display("FAIL basic_empty actual=%b required=00", vc_state[1:0]); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 7; i++) begin
      set_in(1, 1, rnd_flit(), 0);
      tick();
    end
    set_in(1, 1, rnd_flit(), 0);
    total++; if (vc_state[3:2] !== 2'b10) begin bad++; $display("FAIL fill_almost actual=%b required=10", vc_state[3:2]); end
    tick();
    set_in(1, 1, rnd_flit(), 0);
    total++; if (vc_state[3:2] !== 2'b11) begin bad++; $display("FAIL fill_full actual=%b required=11", vc_state[3:2]); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready actual=%b required=0", in_ready); end
    tick();
    set_in(0, 1, '0, 0);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf_pulse actual=%b required=1", overflow); end
    tick();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf_clear actual=%b required=0", overflow); end
    total++; if (vc_state[3:2] !== 2'b11) begin bad++; $display("FAIL fill_still_full actual=%b required=11", vc_state[3:2]); end
    for (int i = 0; i < D; i++) begin
      set_in(0, 0, '0, 1);
      total++; if (out_flit !== m_flit()) begin bad++; $display("FAIL fill_drain%0d actual=%h required=%h", i, out_flit, m_flit()); end
      tick();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fill_drained actual=%b required=0", out_valid); end
  endtask

  task automatic test_round_robin();
    logic [VCW-1:0] order [4];
    order = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      set_in(1, i / 2, rnd_flit(), 0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, '0, 1);
      total++; if (out_vc !== order[i]) begin bad++; $display("FAIL rr_grant%0d actual=%0d required=%0d", i, out_vc, order[i]); end
      total++; if (out_flit !== m_flit()) begin bad++; $display("FAIL rr_flit%0d actual=%h required=%h", i, out_flit, m_flit()); end
      tick();
    end
  endtask

  task automatic test_lock();
    logic [FW-1:0] f1;
    f1 = rnd_flit();
    set_in(1, 1, f1, 0);
    tick();
    set_in(1, 0, rnd_flit(), 0);
    total++; if (out_vc !== 1'b1) begin bad++; $display("FAIL lock_grant actual=%0d required=1", out_vc); end
    tick();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, '0, 0);
      total++; if (out_vc !== 1'b1) begin bad++; $display("FAIL lock_vc%0d actual=%0d required=1", i, out_vc); end
      total++; if (out_flit !== f1) begin bad++; $display("FAIL lock_flit%0d actual=%h required=%h", i, out_flit, f1); end
      tick();
    end
    set_in(0, 0, '0, 1);
    tick();
    set_in(0, 0, '0, 0);
    total++; if (out_vc !== 1'b0) begin bad++; $display("FAIL lock_next actual=%0d required=0", out_vc); end
    total++; if (out_flit !== m_flit()) begin bad++; $display("FAIL lock_next_flit actual=%h required=%h", out_flit, m_flit()); end
    set_in(0, 0, '0, 1);
    tick();
  endtask

  task automatic test_stream();
    set_in(1, 0, rnd_flit(), 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      set_in(1, 0, rnd_flit(), 1);
      total++; if (vc_state[1:0] !== 2'b01) begin bad++; $display("FAIL stream_state%0d actual=%b required=01", i, vc_state[1:0]); end
      total++; if (out_flit !== m_flit()) begin bad++; $display("FAIL stream_flit%0d actual=%h required=%h", i, out_flit, m_flit()); end
      tick();
    end
    set_in(0, 0, '0, 1);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, NV - 1), rnd_flit(),
             (i < 120) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0));
      total++; if (out_valid !== m_valid()) begin bad++; $display("FAIL rnd_valid cyc=%0d actual=%b required=%b", i, out_valid, m_valid()); end
      total++; if (out_vc !== m_vc()) begin bad++; $display("FAIL rnd_vc cyc=%0d actual=%0d required=%0d", i, out_vc, m_vc()); end
      total++; if (out_flit !== m_flit()) begin bad++; $display("FAIL rnd_flit cyc=%0d actual=%h required=%h", i, out_flit, m_flit()); end
      total++; if (in_ready !== m_ready()) begin bad++; $display("FAIL rnd_in_ready cyc=%0d actual=%b required=%b", i, in_ready, m_ready()); end
      total++; if (vc_state !== m_states()) begin bad++; $display("FAIL rnd_state cyc=%0d actual=%b required=%b", i, vc_state, m_states()); end
      total++; if (overflow !== exp_ovf) begin bad++; $display("FAIL rnd_overflow cyc=%0d actual=%b required=%b", i, overflow, exp_ovf); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    logic [FW-1:0] f;
    for (int i = 0; i < 4; i++) begin
      set_in(1, i % 2, rnd_flit(), 0);
      tick();
    end
    set_in(0, 0, '0, 0);
    #2 nrst = 1'b0;
    #1;
    model_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid actual=%b required=0", out_valid); end
    total++; if (vc_state !== '0) begin bad++; $display("FAIL arst_state actual=%b required=0", vc_state); end
    total++; if (out_flit !== '0) begin bad++; $display("FAIL arst_flit actual=%h required=0", out_flit); end
    @(posedge clk);
    #2 nrst = 1'b1;
    f = rnd_flit();
    set_in(1, 1, f, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_no_fallthrough actual=%b required=0", out_valid); end
    tick();
    set_in(0, 0, '0, 0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL arst_push_valid actual=%b required=1", out_valid); end
    total++; if (out_vc !== 1'b1) begin bad++; $display("FAIL arst_push_vc actual=%0d required=1", out_vc); end
    total++; if (out_flit !== f) begin bad++; $display("FAIL arst_push_flit actual=%h required=%h", out_flit, f); end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #3 nrst = 1'b1;
    test_reset();
    test_basic();
    test_fill();
    test_round_robin();
    test_lock();
    test_stream();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vc_flit_buffer.md
# vc_flit_buffer

Parametrised multi-virtual-channel flit buffer for the NoC router input port. It holds up to DEPTH flits in each of NUM_VC independent FIFOs and reports a per-channel buffer_state_t (EMPTY/VACANT/ALMOST_FULL/FULL). Stored flits drain through one shared output, arbitrated round-robin across non-empty channels. It sits between the UART RX flit deserialiser and the routing/ack logic, and replaces the single-queue flit_buffer_t.

## Interface
- FLIT_WIDTH, 128: flit width in bits (types::FLIT_WIDTH).
- NUM_VC, 2: number of virtual channels; legal range 1..16.
- DEPTH, 8: entries per channel; must be a power of two and at least 2.
- VCW, derived: max(1, $clog2(NUM_VC)).
- clk  in  1  system clock; every register samples on the rising edge.
- nrst  in  1  asynchronous, active-low reset.
- in_valid  in  1  write request.
- in_vc  in  VCW  target channel; values at or above NUM_VC are illegal and the write is dropped.
- in_flit  in  FLIT_WIDTH  flit to store.
- in_ready  out  1  high when channel in_vc is not FULL (combinational from in_vc).
- out_valid  out  1  high when any channel is non-empty.
- out_vc  out  VCW  channel currently granted.
- out_flit  out  FLIT_WIDTH  head flit of out_vc.
- out_ready  in  1  consumer accepts the output.
- vc_state  out  2*NUM_VC  per-channel buffer_state_t; channel i occupies bits [2i+1:2i].
- overflow  out  1  one-cycle pulse when a write is dropped.

## Operation
- Per channel: head pointer, tail pointer (log2(DEPTH) bits, natural wrap) and count ($clog2(DEPTH)+1 bits). Storage is DEPTH×FLIT_WIDTH per channel.
- Push: occurs when in_valid && in_ready && in_vc < NUM_VC. The flit is written at tail, tail increments, count increments.
- Drop: occurs when in_valid && (channel FULL or in_vc ≥ NUM_VC). Storage is unchanged and overflow=1 on the next cycle, for one cycle. The drop maps to RX_BUFFER_OVERFLOW at the system level.
- Pop: occurs when out_valid && out_ready. Head of out_vc increments and its count decrements.
- Simultaneous push and pop on the same channel: both take effect and count is unchanged. A FULL channel still refuses the push (in_ready=0) even while popping, with no bypass.
- State per channel, from count:
  - 0 → EMPTY.
  - 1..DEPTH-2 → VACANT.
  - DEPTH-1 → ALMOST_FULL.
  - DEPTH → FULL.
  - With DEPTH=2, count 1 is ALMOST_FULL.
- Arbitration:
  - last_grant register holds the previously granted channel.
  - The grant is the first non-empty channel searched from last_grant+1 upward, wrapping modulo NUM_VC.
  - last_grant updates to out_vc only on a pop.
  - While out_valid && !out_ready, out_vc and out_flit must stay stable. A new push to a higher-priority channel must not change the grant.
  - To meet this, the grant is held in a registered "locked" flag. The flag sets when out_valid && !out_ready and clears on a pop.
- Pointer wrap: tail/head go from DEPTH-1 to 0 with no special casing.

## Timing
- Reset (nrst low, asynchronous):
  - All pointers and counts go to 0, every vc_state is EMPTY (2'b00).
  - out_valid=0, overflow=0, locked=0, last_grant=NUM_VC-1 (so VC0 wins first). out_vc=0 and out_flit=0 while out_valid=0.
  - in_ready=1 for all legal in_vc.
  - Storage contents are not reset.
- Reset mid-transfer discards all stored flits. After nrst rises, the first edge may accept a write.
- Write-to-read latency: a flit pushed at edge N is visible on out_flit with out_valid=1 after edge N. There is no same-cycle fall-through.
- vc_state, in_ready and out_valid reflect the registered counts after each edge. out_vc and out_flit are combinational from registers and the lock.
- Throughput: one push and one pop per cycle, sustained.

## Test plan
- Reset, then push 3 flits (0xA1, 0xA2, 0xA3) to VC0 on consecutive cycles with out_ready=0. Required: vc_state[1:0]=VACANT and out_flit=0xA1. Then with out_ready=1, three pops in order, after which VC0 is EMPTY.
- DEPTH=8: push 7 flits to VC1. Required: ALMOST_FULL. 8th push → FULL and in_ready=0. 9th push → overflow pulses for exactly one cycle and the contents are unchanged.
- VC0 and VC1 each hold 2 flits, out_ready held high. Required grant order VC0, VC1, VC0, VC1.
- VC1 granted with out_ready=0, then push to VC0. Required: out_vc stays 1 and out_flit is stable for 5 cycles. Release → VC1 pops, then VC0 is granted.
- Continuous push and pop on VC0 for 20 cycles. Required: wrap exercised, data order preserved, count steady at 1.
- Assert nrst with 4 flits stored. Required: out_valid=0 asynchronously and all states EMPTY. Push after release → flit appears one cycle later.
